// File: rtl/plu_seq_ctrl.sv
// Pass sequencer for a pipelined lookup unit: loads operands, walks the pipeline
// stages one per cycle, and iterates with feedback until converged or MAX_ITER.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | load activation and weight registers, clear counters
// RUN   | one pipeline stage written per cycle, stg walks 0..STAGES-1
// CHECK | pass complete: count it, then finish or feed back for another pass
// DONE  | one-cycle completion pulse
module plu_seq_ctrl #(
    parameter int STAGES   = 3,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              converged,
    input  logic              abort,
    output logic              a_we,
    output logic              w_we,
    output logic [STAGES-1:0] stage_we,
    output logic              fb_we,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_cnt
);

    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [SW-1:0] STG_LAST = SW'(STAGES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SW-1:0]     stg;
    logic              mode_q;
    logic [ITER_W-1:0] iter_inc;
    logic              last_pass;
    logic              accept;
    logic              cancel;

    assign iter_inc  = iter_cnt + ITER_W'(1);
    assign last_pass = (iter_inc == ITER_W'(MAX_ITER));
    assign accept    = (state == IDLE) && start && !abort;
    assign cancel    = (state != IDLE) && abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_we      = 1'b0;
        w_we      = 1'b0;
        stage_we  = '0;
        fb_we     = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                a_we      = 1'b1;
                w_we      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                stage_we = STAGES'(1) << stg;
                if (stg == STG_LAST) state_nxt = CHECK;
            end
            CHECK: begin
                if (!mode_q || converged || last_pass) begin
                    state_nxt = DONE;
                end else begin
                    fb_we     = 1'b1;
                    state_nxt = RUN;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // abort wins over every transition; only rst outranks it
        if (cancel) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg      <= '0;
            iter_cnt <= '0;
            timeout  <= 1'b0;
            mode_q   <= 1'b0;
        end else if (!cancel) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_q  <= mode;
                        timeout <= 1'b0;
                    end
                end
                LOAD: begin
                    iter_cnt <= '0;
                    stg      <= '0;
                end
                RUN: begin
                    if (stg != STG_LAST) stg <= stg + SW'(1);
                end
                CHECK: begin
                    iter_cnt <= iter_inc;
                    stg      <= '0;
                    if (mode_q && !converged && last_pass) timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
